// File: rtl/reg_bank_seq.sv
// Bank of NREG WIDTH-bit registers sharing one funsel/din bus, with sticky wrap flags,
// zero flags and per-register byte assembly with a completion pulse; one-cycle latency, no handshake.
module reg_bank_seq #(
    parameter int WIDTH = 32,
    parameter int NREG  = 4,
    parameter int IN_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREG-1:0]       en,
    input  logic [2:0]            funsel,
    input  logic [IN_W-1:0]       din,
    output logic [NREG*WIDTH-1:0] q,
    output logic [NREG-1:0]       zero,
    output logic [NREG-1:0]       wrap,
    output logic [NREG-1:0]       asm_done
);

    localparam int B  = WIDTH / 8;
    localparam int CW = $clog2(B + 1);

    localparam logic [2:0] OP_DEC  = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_LOAD = 3'b010;
    localparam logic [2:0] OP_CLR  = 3'b011;
    localparam logic [2:0] OP_LDB  = 3'b100;
    localparam logic [2:0] OP_PART = 3'b101;
    localparam logic [2:0] OP_ASM  = 3'b110;
    localparam logic [2:0] OP_LDS  = 3'b111;

    // Ones over the din field; zero-width upper part when IN_W == WIDTH.
    localparam logic [WIDTH-1:0] LOW_MASK = ~({WIDTH{1'b1}} << IN_W);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(B - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] regs [NREG];
    logic [CW-1:0]    cnt  [NREG];

    logic [WIDTH-1:0] din_z;
    logic [WIDTH-1:0] din_s;
    logic [WIDTH-1:0] din_b;

    assign din_z = WIDTH'(din);
    assign din_s = din_z | (din[IN_W-1] ? ~LOW_MASK : '0);
    assign din_b = WIDTH'(din[7:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
            wrap     <= '0;
            asm_done <= '0;
        end else begin
            asm_done <= '0;
            for (int i = 0; i < NREG; i++) begin
                if (en[i]) begin
                    // Defaults for every op; inc/dec and assembly override below.
                    cnt[i]  <= '0;
                    wrap[i] <= 1'b0;
                    case (funsel)
                        OP_DEC: begin
                            regs[i] <= regs[i] - ONE;
                            wrap[i] <= wrap[i] | (regs[i] == '0);
                        end
                        OP_INC: begin
                            regs[i] <= regs[i] + ONE;
                            wrap[i] <= wrap[i] | (regs[i] == {WIDTH{1'b1}});
                        end
                        OP_LOAD: regs[i] <= din_z;
                        OP_CLR:  regs[i] <= '0;
                        OP_LDB:  regs[i] <= din_b;
                        OP_PART: regs[i] <= (regs[i] & ~LOW_MASK) | din_z;
                        OP_ASM: begin
                            regs[i] <= {regs[i][WIDTH-9:0], din[7:0]};
                            if (cnt[i] == CNT_LAST) begin
                                asm_done[i] <= 1'b1;
                            end else begin
                                cnt[i] <= cnt[i] + CNT_ONE;
                            end
                        end
                        default: regs[i] <= din_s;
                    endcase
                end
            end
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_out
        assign q[g*WIDTH +: WIDTH] = regs[g];
        assign zero[g]             = (regs[g] == '0);
    end

endmodule

// File: tb/tb_reg_bank_seq.sv
// Directed + random stimulus for reg_bank_seq (4x32/16 and 2x64/32), expected values queued at drive time.
module tb_reg_bank_seq;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int I  = 16;
    localparam int W2 = 64;
    localparam int N2 = 2;
    localparam int I2 = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic [N-1:0]   en = '0;
    logic [2:0]     funsel = '0;
    logic [I-1:0]   din = '0;
    logic [N*W-1:0] q;
    logic [N-1:0]   zero, wrap, asm_done;

    logic             rst2 = 1'b1;
    logic [N2-1:0]    en2 = '0;
    logic [2:0]       funsel2 = '0;
    logic [I2-1:0]    din2 = '0;
    logic [N2*W2-1:0] q2;
    logic [N2-1:0]    zero2, wrap2, asm_done2;

    reg_bank_seq #(.WIDTH(W), .NREG(N), .IN_W(I)) dut_a (
        .clk(clk), .rst(rst), .en(en), .funsel(funsel), .din(din),
        .q(q), .zero(zero), .wrap(wrap), .asm_done(asm_done)
    );

    reg_bank_seq #(.WIDTH(W2), .NREG(N2), .IN_W(I2)) dut_b (
        .clk(clk), .rst(rst2), .en(en2), .funsel(funsel2), .din(din2),
        .q(q2), .zero(zero2), .wrap(wrap2), .asm_done(asm_done2)
    );

    typedef struct {
        logic [N*W-1:0] q;
        logic [N-1:0]   zero;
        logic [N-1:0]   wrap;
        logic [N-1:0]   done;
    } exp_t;

    typedef struct {
        logic [W2-1:0] q0;
        logic [N2-1:0] done;
    } exp_b_t;

    exp_t   sb[$];
    exp_b_t sb_b[$];

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_q   [N];
    int           m_cnt [N];
    logic [N-1:0] m_wrap;
    logic [N-1:0] m_done;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference behaviour written with the fixed 32/16 geometry.
    task automatic model_a(input logic r, input logic [N-1:0] e, input logic [2:0] f, input logic [I-1:0] d);
        m_done = '0;
        for (int i = 0; i < N; i++) begin
            if (r) begin
                m_q[i] = '0; m_cnt[i] = 0; m_wrap[i] = 1'b0;
            end else if (e[i]) begin
                if (f != 3'b000 && f != 3'b001) m_wrap[i] = 1'b0;
                if (f != 3'b110) m_cnt[i] = 0;
                case (f)
                    3'b000: begin if (m_q[i] == 32'h0) m_wrap[i] = 1'b1; m_q[i] = m_q[i] - 32'd1; end
                    3'b001: begin if (m_q[i] == 32'hFFFF_FFFF) m_wrap[i] = 1'b1; m_q[i] = m_q[i] + 32'd1; end
                    3'b010: m_q[i] = {16'h0, d};
                    3'b011: m_q[i] = 32'h0;
                    3'b100: m_q[i] = {24'h0, d[7:0]};
                    3'b101: m_q[i] = {m_q[i][31:16], d};
                    3'b110: begin
                        m_q[i] = {m_q[i][23:0], d[7:0]};
                        if (m_cnt[i] == 3) begin m_cnt[i] = 0; m_done[i] = 1'b1; end
                        else m_cnt[i] = m_cnt[i] + 1;
                    end
                    default: m_q[i] = {{16{d[15]}}, d};
                endcase
            end
        end
    endtask

    task automatic step_a(input logic r, input logic [N-1:0] e, input logic [2:0] f, input logic [I-1:0] d);
        exp_t x;
        rst = r; en = e; funsel = f; din = d;
        model_a(r, e, f, d);
        for (int i = 0; i < N; i++) begin
            x.q[i*W +: W] = m_q[i];
            x.zero[i]     = (m_q[i] == 32'h0);
        end
        x.wrap = m_wrap;
        x.done = m_done;
        sb.push_back(x);
        @(posedge clk); #1;
        x = sb.pop_front();
        chk("a_q", 128'(q), 128'(x.q));
        chk("a_zero", 128'(zero), 128'(x.zero));
        chk("a_wrap", 128'(wrap), 128'(x.wrap));
        chk("a_done", 128'(asm_done), 128'(x.done));
    endtask

    task automatic step_b(input logic r, input logic [N2-1:0] e, input logic [2:0] f,
                          input logic [I2-1:0] d, input logic [W2-1:0] eq, input logic [N2-1:0] ed);
        exp_b_t x;
        rst2 = r; en2 = e; funsel2 = f; din2 = d;
        x.q0 = eq; x.done = ed;
        sb_b.push_back(x);
        @(posedge clk); #1;
        x = sb_b.pop_front();
        chk("b_q0", 128'(q2[W2-1:0]), 128'(x.q0));
        chk("b_done", 128'(asm_done2), 128'(x.done));
    endtask

    logic [31:0]   bytes4;
    logic [W2-1:0] acc;

    initial begin
        // Reset state
        step_a(1'b1, 4'b1111, 3'b001, 16'hFFFF);
        chk("rst_zero", 128'(zero), 128'hF);
        chk("rst_q", 128'(q), 128'h0);

        // Sign-extended load
        step_a(1'b0, 4'b0001, 3'b111, 16'h8001);
        chk("sext_q0", 128'(q[31:0]), 128'hFFFF_8001);
        chk("sext_zero", 128'(zero), 128'hE);

        // Increment wrap, dec keeps sticky flag, load clears it
        step_a(1'b0, 4'b0001, 3'b111, 16'hFFFF);
        step_a(1'b0, 4'b0001, 3'b001, 16'h0);
        chk("inc_wrap_q0", 128'(q[31:0]), 128'h0);
        chk("inc_wrap_flag", 128'(wrap[0]), 128'h1);
        step_a(1'b0, 4'b0001, 3'b000, 16'h0);
        chk("dec_q0", 128'(q[31:0]), 128'hFFFF_FFFF);
        chk("dec_wrap_sticky", 128'(wrap[0]), 128'h1);
        step_a(1'b0, 4'b0001, 3'b010, 16'h0005);
        chk("load_clears_wrap", 128'({q[31:0], 3'b000, wrap[0]}), 128'({32'h5, 4'h0}));

        // Byte assembly on register 1
        bytes4 = 32'h12345678;
        for (int k = 0; k < 4; k++) begin
            step_a(1'b0, 4'b0010, 3'b110, {8'h00, bytes4[31-8*k -: 8]});
            chk("asm_pulse", 128'(asm_done), (k == 3) ? 128'h2 : 128'h0);
        end
        chk("asm_word", 128'(q[63:32]), 128'h1234_5678);
        step_a(1'b0, 4'b0010, 3'b110, 16'h009A);
        chk("asm_fifth", 128'({q[63:32], asm_done}), 128'({32'h3456_789A, 4'h0}));

        // Interrupted assembly: count restarts after the inc
        step_a(1'b0, 4'b0010, 3'b011, 16'h0);
        step_a(1'b0, 4'b0010, 3'b110, 16'h0011);
        step_a(1'b0, 4'b0010, 3'b110, 16'h0022);
        step_a(1'b0, 4'b0010, 3'b001, 16'h0);
        for (int k = 0; k < 4; k++) begin
            step_a(1'b0, 4'b0010, 3'b110, 16'h00A0 + 16'(k));
            chk("int_pulse", 128'(asm_done), (k == 3) ? 128'h2 : 128'h0);
        end

        // Partial load then broadcast clear
        bytes4 = 32'hAABBCCDD;
        for (int k = 0; k < 4; k++) step_a(1'b0, 4'b0100, 3'b110, {8'h00, bytes4[31-8*k -: 8]});
        step_a(1'b0, 4'b0100, 3'b101, 16'h1234);
        chk("partial_q2", 128'(q[95:64]), 128'hAABB_1234);
        step_a(1'b0, 4'b1111, 3'b011, 16'h0);
        chk("bcast_zero", 128'(zero), 128'hF);

        // Reset mid-assembly
        for (int k = 0; k < 3; k++) step_a(1'b0, 4'b1111, 3'b110, 16'h0040 + 16'(k));
        step_a(1'b1, 4'b1111, 3'b110, 16'h00FF);
        chk("rst_mid", 128'({q, wrap, asm_done}), 128'h0);
        for (int k = 0; k < 4; k++) begin
            step_a(1'b0, 4'b1111, 3'b110, 16'h0050 + 16'(k));
            chk("post_rst_pulse", 128'(asm_done), (k == 3) ? 128'hF : 128'h0);
        end

        // Random mix against the model
        for (int k = 0; k < 300; k++) begin
            step_a(($urandom_range(0, 29) == 0), 4'($urandom), 3'($urandom), 16'($urandom));
        end

        // 64-bit bank: reset mid-assembly, then eight bytes per pulse
        step_b(1'b1, 2'b11, 3'b110, 32'h0, 64'h0, 2'b00);
        acc = '0;
        for (int k = 0; k < 3; k++) begin
            acc = {acc[55:0], 8'hE0 + 8'(k)};
            step_b(1'b0, 2'b01, 3'b110, 32'hFFFF_FF00 | 32'(8'hE0 + 8'(k)), acc, 2'b00);
        end
        step_b(1'b1, 2'b11, 3'b110, 32'h0000_00FF, 64'h0, 2'b00);
        acc = '0;
        for (int k = 0; k < 8; k++) begin
            acc = {acc[55:0], 8'(k + 1)};
            step_b(1'b0, 2'b01, 3'b110, 32'(k + 1), acc, (k == 7) ? 2'b01 : 2'b00);
        end
        chk("b_word", 128'(q2[63:0]), 128'h0102_0304_0506_0708);
        acc = 64'h0203_0405_0607_0809;
        step_b(1'b0, 2'b01, 3'b110, 32'h0000_0009, acc, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
